// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter: FSM state encoding, the
// read-owner tag encoding and the default widths/limits.
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W     = 14;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;
    localparam int BE_W           = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Identifies which requester owns the read data returning next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Width needed to hold a saturating counter that counts up to maxVal.
    function automatic int cnt_width(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_prio.sv
// ---------------------------------------------------------------------------
// arb_prio
// Purely combinational fixed-priority arbiter between the data port and the
// fetch port. Data wins by default; fetch wins once it has been starved for
// STARVE_MAX cycles. The starvation counter itself lives in the parent.
//
// Ports:
//   enable_i     - arbitration allowed this cycle (RUN state, not in reset)
//   ifReq_i      - fetch request
//   dReq_i       - data request
//   starveCnt_i  - current fetch starvation count
//   ifGnt_o      - fetch granted
//   dGnt_o       - data granted
// ---------------------------------------------------------------------------
module arb_prio #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             enable_i,
    input  logic             ifReq_i,
    input  logic             dReq_i,
    input  logic [CNT_W-1:0] starveCnt_i,
    output logic             ifGnt_o,
    output logic             dGnt_o
);

    logic starved;

    // Data port has priority unless the fetch port has hit its starvation
    // limit while still requesting; at most one grant is ever raised.
    always_comb begin
        starved = (starveCnt_i == CNT_W'(STARVE_MAX));
        ifGnt_o = 1'b0;
        dGnt_o  = 1'b0;
        if (enable_i) begin
            if (dReq_i && !(ifReq_i && starved)) begin
                dGnt_o = 1'b1;
            end else if (ifReq_i) begin
                ifGnt_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port RAM between an instruction fetch port, a data port
// and a bulk loader. In RUN the fetch and data ports are arbitrated each
// cycle; a loader start drains the outstanding read (DRAIN) and then hands
// the RAM exclusively to the loader (LOAD) until it signals done.
//
// Ports:
//   clk, rst                       - clock, async active-high reset
//   if_req/if_addr/if_gnt          - fetch request, address, grant
//   if_rvalid/if_rdata             - fetch read return (one cycle after grant)
//   d_req/d_we/d_be/d_addr/d_wdata - data request, write enable, byte enables
//   d_gnt/d_rvalid/d_rdata         - data grant and read return
//   ld_start/ld_valid/ld_addr/
//   ld_wdata/ld_done/ld_gnt        - loader control, write beats, grant
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata            - RAM port (rdata valid cycle after en)
//   pipe_stall                     - some requester is blocked or not in RUN
//   load_active                    - FSM is in LOAD
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_done,
    output logic              ld_gnt,
    output logic              mem_en,
    output logic [BE_W-1:0]   mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall,
    output logic              load_active
);

    localparam int CNT_W = cnt_width(STARVE_MAX);

    state_e           state_q, state_d;
    owner_e           tag_q, tag_d;
    logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
    logic             arbEnable;
    logic             ifWin;
    logic             dWin;

    // Grants are combinational, so they are also suppressed while reset is
    // held to keep the RAM port quiet during reset.
    assign arbEnable = (state_q == ST_RUN) && !rst;

    arb_prio #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_arb_prio (
        .enable_i    (arbEnable),
        .ifReq_i     (if_req),
        .dReq_i      (d_req),
        .starveCnt_i (starveCnt_q),
        .ifGnt_o     (ifWin),
        .dGnt_o      (dWin)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a load start drains for exactly one cycle so the
    // read granted alongside it can return, then the loader owns the RAM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (ld_start) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_LOAD;
            ST_LOAD:  if (ld_done) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Output logic: RAM port mux, grants, status and read-return steering.
    // The loader beat is only considered in LOAD, where the arbiter is off.
    always_comb begin
        if_gnt      = ifWin;
        d_gnt       = dWin;
        ld_gnt      = 1'b0;
        mem_en      = 1'b0;
        mem_we      = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        load_active = (state_q == ST_LOAD);
        if (dWin) begin
            mem_en    = 1'b1;
            mem_we    = d_we ? d_be : '0;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (ifWin) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if ((state_q == ST_LOAD) && ld_valid && !rst) begin
            ld_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_we    = '1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
        pipe_stall = (if_req && !ifWin) || (d_req && !dWin) || (state_q != ST_RUN);
        if_rvalid  = (tag_q == OWN_IF);
        d_rvalid   = (tag_q == OWN_D);
        if_rdata   = if_rvalid ? mem_rdata : '0;
        d_rdata    = d_rvalid ? mem_rdata : '0;
    end

    // Next read-owner tag and fetch starvation count. The counter only moves
    // in RUN; while draining or loading it keeps its value.
    always_comb begin
        tag_d = OWN_NONE;
        if (ifWin) begin
            tag_d = OWN_IF;
        end else if (dWin && !d_we) begin
            tag_d = OWN_D;
        end
        starveCnt_d = starveCnt_q;
        if (state_q == ST_RUN) begin
            if (!if_req || ifWin) begin
                starveCnt_d = '0;
            end else if (starveCnt_q != CNT_W'(STARVE_MAX)) begin
                starveCnt_d = starveCnt_q + CNT_W'(1);
            end
        end
    end

    // Read tag and starvation counter registers; reset aborts any read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q       <= OWN_NONE;
            starveCnt_q <= '0;
        end else begin
            tag_q       <= tag_d;
            starveCnt_q <= starveCnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives directed and random traffic into mem_port_arbiter, predicts grants
// and RAM port activity with a cycle-level behavioural model, and queues the
// expected read returns for an independent monitor process to check.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int MEM_WORDS  = 1 << ADDR_W;

    typedef struct {
        bit                ifReq;
        logic [ADDR_W-1:0] ifAddr;
        bit                dReq;
        bit                dWe;
        logic [3:0]        dBe;
        logic [ADDR_W-1:0] dAddr;
        logic [DATA_W-1:0] dWdata;
        bit                ldStart;
        bit                ldValid;
        logic [ADDR_W-1:0] ldAddr;
        logic [DATA_W-1:0] ldWdata;
        bit                ldDone;
    } stim_t;

    typedef struct {
        int                due;
        bit                isD;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              ld_start, ld_valid, ld_done, ld_gnt;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              pipe_stall, load_active;

    bit [DATA_W-1:0]   ramMem [MEM_WORDS];
    bit [DATA_W-1:0]   refMem [MEM_WORDS];
    logic [DATA_W-1:0] ramRdata;
    rd_t               sbQ [$];
    int                mState;
    int                mStarve;
    int                cycleIdx;
    int                total;
    int                bad;

    // Free-running clock: rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_be        (d_be),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_wdata    (ld_wdata),
        .ld_done     (ld_done),
        .ld_gnt      (ld_gnt),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pipe_stall  (pipe_stall),
        .load_active (load_active)
    );

    assign mem_rdata = ramRdata;

    // Behavioural single-port RAM with byte-enable writes and one-cycle reads.
    initial begin
        ramRdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            ramMem[i] = DATA_W'(i) * 32'h9E37_79B1;
        end
        ramMem[16] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            if (mem_en === 1'b1) begin
                if (mem_we == 4'h0) begin
                    ramRdata <= ramMem[mem_addr];
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_we[b]) ramMem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cycleIdx, act, exp);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s.ifReq = 0; s.ifAddr = '0; s.dReq = 0; s.dWe = 0; s.dBe = '0;
        s.dAddr = '0; s.dWdata = '0; s.ldStart = 0; s.ldValid = 0;
        s.ldAddr = '0; s.ldWdata = '0; s.ldDone = 0;
        return s;
    endfunction

    task automatic drivePins(input stim_t s);
        if_req = s.ifReq; if_addr = s.ifAddr;
        d_req = s.dReq; d_we = s.dWe; d_be = s.dBe; d_addr = s.dAddr; d_wdata = s.dWdata;
        ld_start = s.ldStart; ld_valid = s.ldValid; ld_addr = s.ldAddr;
        ld_wdata = s.ldWdata; ld_done = s.ldDone;
    endtask

    // Reference model for one cycle: decide the winner from the priority and
    // starvation rules, check the RAM port, queue read returns, advance state.
    task automatic checkOutput(input stim_t s);
        bit                eIf, eD, eLd, eEn, eStall;
        logic [3:0]        eWe;
        logic [ADDR_W-1:0] eAddr;
        logic [DATA_W-1:0] eWd;
        rd_t               r;
        eIf = 0; eD = 0; eLd = 0; eEn = 0; eWe = '0; eAddr = '0; eWd = '0;
        if (mState == 0) begin
            if (s.dReq && !(s.ifReq && mStarve == STARVE_MAX)) eD = 1;
            else if (s.ifReq) eIf = 1;
        end else if (mState == 2 && s.ldValid) begin
            eLd = 1;
        end
        if (eD) begin
            eEn = 1; eAddr = s.dAddr; eWd = s.dWdata; eWe = s.dWe ? s.dBe : 4'h0;
        end else if (eIf) begin
            eEn = 1; eAddr = s.ifAddr;
        end else if (eLd) begin
            eEn = 1; eAddr = s.ldAddr; eWd = s.ldWdata; eWe = 4'hF;
        end
        eStall = (s.ifReq && !eIf) || (s.dReq && !eD) || (mState != 0);
        cmp("if_gnt", if_gnt, eIf);
        cmp("d_gnt", d_gnt, eD);
        cmp("ld_gnt", ld_gnt, eLd);
        cmp("mem_en", mem_en, eEn);
        cmp("mem_we", mem_we, eWe);
        if (eEn) cmp("mem_addr", mem_addr, eAddr);
        if (eWe != 0) cmp("mem_wdata", mem_wdata, eWd);
        cmp("pipe_stall", pipe_stall, eStall);
        cmp("load_active", load_active, mState == 2);
        if (eIf || (eD && !s.dWe)) begin
            r.due  = cycleIdx + 1;
            r.isD  = eD;
            r.data = refMem[eAddr];
            sbQ.push_back(r);
        end
        for (int b = 0; b < 4; b++) begin
            if (eWe[b]) refMem[eAddr][8*b +: 8] = eWd[8*b +: 8];
        end
        if (mState == 0) begin
            if (!s.ifReq || eIf) mStarve = 0;
            else if (mStarve < STARVE_MAX) mStarve++;
        end
        case (mState)
            0: if (s.ldStart) mState = 1;
            1: mState = 2;
            default: if (s.ldDone) mState = 0;
        endcase
    endtask

    // One clock cycle: inputs change just after the rising edge, the
    // combinational response is checked 2 time units later.
    task automatic applyStimulus(input stim_t s);
        cycleIdx++;
        drivePins(s);
        #2;
        checkOutput(s);
        @(posedge clk);
        #1;
    endtask

    // Holds reset for n cycles; any queued read is abandoned and every
    // output must read zero while reset is asserted.
    task automatic resetPulse(input int n);
        for (int i = 0; i < n; i++) begin
            cycleIdx++;
            rst = 1'b1;
            drivePins(idleStim());
            sbQ.delete();
            mState  = 0;
            mStarve = 0;
            #2;
            cmp("rst_if_gnt", if_gnt, 0);
            cmp("rst_d_gnt", d_gnt, 0);
            cmp("rst_ld_gnt", ld_gnt, 0);
            cmp("rst_mem_en", mem_en, 0);
            cmp("rst_mem_we", mem_we, 0);
            cmp("rst_load_active", load_active, 0);
            cmp("rst_if_rvalid", if_rvalid, 0);
            cmp("rst_d_rvalid", d_rvalid, 0);
            cmp("rst_if_rdata", if_rdata, 0);
            cmp("rst_d_rdata", d_rdata, 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // Monitor: every falling edge, expect exactly the read return that the
    // scoreboard says is due this cycle, and zeros otherwise.
    task automatic monitorStep();
        bit                eIfV, eDV;
        logic [DATA_W-1:0] eIfD, eDD;
        rd_t               r;
        eIfV = 0; eDV = 0; eIfD = '0; eDD = '0;
        if (sbQ.size() > 0 && sbQ[0].due == cycleIdx) begin
            r = sbQ.pop_front();
            if (r.isD) begin eDV = 1; eDD = r.data; end
            else begin eIfV = 1; eIfD = r.data; end
        end
        cmp("if_rvalid", if_rvalid, eIfV);
        cmp("if_rdata", if_rdata, eIfD);
        cmp("d_rvalid", d_rvalid, eDV);
        cmp("d_rdata", d_rdata, eDD);
    endtask

    initial begin
        stim_t s;
        total = 0; bad = 0; cycleIdx = 0; mState = 0; mStarve = 0;
        rst = 1'b1;
        drivePins(idleStim());
        for (int i = 0; i < MEM_WORDS; i++) refMem[i] = DATA_W'(i) * 32'h9E37_79B1;
        refMem[16] = 32'hDEAD_BEEF;
        fork
            forever begin
                @(negedge clk);
                monitorStep();
            end
        join_none
        @(posedge clk);
        #1;
        resetPulse(2);

        // Fetch and data both requesting: data wins four times, then fetch.
        for (int i = 0; i < 10; i++) begin
            s = idleStim();
            s.ifReq = 1; s.ifAddr = ADDR_W'(100 + i);
            s.dReq = 1; s.dAddr = ADDR_W'(200 + i);
            applyStimulus(s);
        end
        applyStimulus(idleStim());

        // Data read of address 0x10, then byte-masked write of 0x20 and readback.
        s = idleStim(); s.dReq = 1; s.dAddr = 14'h10;
        applyStimulus(s);
        s = idleStim(); s.dReq = 1; s.dWe = 1; s.dBe = 4'b0011; s.dAddr = 14'h20; s.dWdata = 32'h1234_5678;
        applyStimulus(s);
        s = idleStim(); s.dReq = 1; s.dAddr = 14'h20;
        applyStimulus(s);
        applyStimulus(idleStim());

        // Load start alongside a granted fetch, drain, three loader writes with
        // done on the last beat, then fetch the loaded words back.
        s = idleStim(); s.ifReq = 1; s.ifAddr = 14'h5; s.ldStart = 1;
        applyStimulus(s);
        s = idleStim(); s.ifReq = 1; s.ifAddr = 14'h6;
        applyStimulus(s);
        for (int i = 0; i < 3; i++) begin
            s = idleStim(); s.ifReq = 1; s.dReq = 1;
            s.ldValid = 1; s.ldAddr = ADDR_W'(i); s.ldWdata = 32'hA000_0000 + DATA_W'(i);
            s.ldDone = (i == 2);
            applyStimulus(s);
        end
        for (int i = 0; i < 3; i++) begin
            s = idleStim(); s.ifReq = 1; s.ifAddr = ADDR_W'(i);
            applyStimulus(s);
        end

        // Stray done in RUN, stray start in LOAD.
        s = idleStim(); s.ldDone = 1; s.ifReq = 1; s.ifAddr = 14'h7;
        applyStimulus(s);
        s = idleStim(); s.ldStart = 1;
        applyStimulus(s);
        applyStimulus(idleStim());
        s = idleStim(); s.ldStart = 1; s.ldValid = 1; s.ldAddr = 14'h30; s.ldWdata = 32'hCAFE_0030;
        applyStimulus(s);
        s = idleStim(); s.ldDone = 1;
        applyStimulus(s);

        // Reset in LOAD after two writes, then reset right after a read grant.
        s = idleStim(); s.ldStart = 1;
        applyStimulus(s);
        applyStimulus(idleStim());
        for (int i = 0; i < 2; i++) begin
            s = idleStim(); s.ldValid = 1; s.ldAddr = ADDR_W'(40 + i); s.ldWdata = $urandom;
            applyStimulus(s);
        end
        resetPulse(1);
        applyStimulus(idleStim());
        s = idleStim(); s.dReq = 1; s.dAddr = 14'h10;
        applyStimulus(s);
        resetPulse(1);
        applyStimulus(idleStim());

        // Randomized traffic over a small address window.
        for (int i = 0; i < 400; i++) begin
            s = idleStim();
            s.ifReq   = ($urandom_range(0, 3) != 0);
            s.ifAddr  = ADDR_W'($urandom_range(0, 63));
            s.dReq    = ($urandom_range(0, 1) != 0);
            s.dWe     = ($urandom_range(0, 1) != 0);
            s.dBe     = 4'($urandom_range(0, 15));
            s.dAddr   = ADDR_W'($urandom_range(0, 63));
            s.dWdata  = $urandom;
            s.ldStart = ($urandom_range(0, 24) == 0);
            s.ldValid = ($urandom_range(0, 1) != 0);
            s.ldAddr  = ADDR_W'($urandom_range(0, 63));
            s.ldWdata = $urandom;
            s.ldDone  = ($urandom_range(0, 7) == 0);
            if (i == 200) resetPulse(1);
            applyStimulus(s);
        end
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        cmp("sb_drained", sbQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL take parameters: ADDR_W, default 14, word address width; DATA_W, default 32, data width; STARVE_MAX, default 4, fetch starvation limit in cycles.
REQ-002 SHALL have port clk, input, 1, CPU clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have fetch ports: if_req in 1; if_addr in ADDR_W; if_gnt out 1; if_rvalid out 1; if_rdata out DATA_W.
REQ-005 SHALL have data ports: d_req in 1; d_we in 1; d_be in 4; d_addr in ADDR_W; d_wdata in DATA_W; d_gnt out 1; d_rvalid out 1; d_rdata out DATA_W.
REQ-006 SHALL have loader ports: ld_start in 1, pulse; ld_valid in 1; ld_addr in ADDR_W; ld_wdata in DATA_W; ld_done in 1, pulse; ld_gnt out 1.
REQ-007 SHALL have RAM ports: mem_en out 1; mem_we out 4; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, valid one cycle after mem_en.
REQ-008 SHALL have status ports: pipe_stall out 1; load_active out 1.

Function
REQ-009 SHALL implement FSM states RUN, DRAIN and LOAD.
REQ-010 RUN: at most one grant per cycle; priority d > if, except fetch wins when starve_cnt == STARVE_MAX.
REQ-011 starve_cnt SHALL increment on each cycle with if_req=1 and if_gnt=0, saturating at STARVE_MAX; it SHALL clear on if_gnt or when if_req=0.
REQ-012 Grant is combinational in the request cycle: mem_en=1; mem_addr/mem_wdata from the winner; mem_we = d_be if d_we else 4'h0; fetch mem_we = 4'h0.
REQ-013 Granted read SHALL raise the matching rvalid exactly one cycle later with rdata=mem_rdata; the owner is held in a registered tag; writes produce no rvalid.
REQ-014 rvalid/rdata for a requester SHALL be 0 in all cycles it has no returning read.
REQ-015 pipe_stall = (if_req & ~if_gnt) | (d_req & ~d_gnt) | (state != RUN), combinational.
REQ-016 RUN plus ld_start SHALL go to DRAIN; that cycle's grant still issues.
REQ-017 DRAIN SHALL last one cycle: no grants; the outstanding read returns; then go to LOAD.
REQ-018 LOAD: if/d never granted; each ld_valid cycle grants the loader (ld_gnt=1, mem_we=4'hF, mem_en=1); load_active=1.
REQ-019 LOAD plus ld_done SHALL return to RUN next cycle; if ld_valid and ld_done coincide, the write completes first.
REQ-020 ld_start outside RUN and ld_done outside LOAD SHALL be ignored.
REQ-021 starve_cnt SHALL hold, not clear, during DRAIN/LOAD.

Reset
REQ-022 rst SHALL force state=RUN, starve_cnt=0, read tag=none.
REQ-023 Output values in reset: all gnt/rvalid/rdata 0, mem_en 0, mem_we 0, load_active 0.
REQ-024 Reset mid-LOAD or mid-read SHALL abort the sequence; no rvalid after reset deassert without a fresh grant.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, the owner tag encoding (NONE/IF/D) and default widths.
REQ-026 The priority/starvation logic SHALL be one sub-module, arb_prio, with combinational grant, counter kept in parent; no other sub-modules.

Verification
REQ-027 if_req and d_req both held, d reads: d granted cycles 0-3, if granted cycle 4 (STARVE_MAX=4), then d again; starve_cnt observed 0.
REQ-028 d read addr 0x10, RAM holds 0xDEADBEEF: d_gnt cycle N, d_rvalid=1 with d_rdata=0xDEADBEEF cycle N+1, if_rvalid=0.
REQ-029 d write be=4'b0011 addr 0x20: mem_we=4'b0011 same cycle, no rvalid next cycle.
REQ-030 ld_start during granted fetch read: if_rvalid in DRAIN, then LOAD, 3 ld_valid writes 0x0-0x2 with mem_we=4'hF, ld_done -> RUN, pipe_stall high throughout DRAIN/LOAD.
REQ-031 rst asserted in LOAD after 2 writes: immediate RUN, load_active=0, all outputs 0, no spurious rvalid.
REQ-032 ld_done in RUN and ld_start in LOAD: no state change.
